// File: rtl/beam_phase_seq_if.sv
// Bus bundle for the beam phase sequencer: command intake, element table,
// phase-calculator handshake and phase register-file write port.
interface beam_phase_seq_if #(
    parameter int unsigned EAW = 8
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic [15:0]    cmd_az;
    logic [15:0]    cmd_el;
    logic           cmd_is_tx;

    logic [EAW-1:0] tbl_addr;
    logic [15:0]    tbl_x;
    logic [15:0]    tbl_y;
    logic [5:0]     tbl_cal;

    logic           pc_start;
    logic           pc_is_tx;
    logic [15:0]    pc_x;
    logic [15:0]    pc_y;
    logic [15:0]    pc_az;
    logic [15:0]    pc_el;
    logic           pc_busy;
    logic           pc_valid;
    logic [5:0]     pc_idx;

    logic           wr_en;
    logic [EAW-1:0] wr_addr;
    logic [5:0]     wr_data;

    logic           busy;
    logic           done;
    logic           err_timeout;

    modport master (
        input  cmd_valid, cmd_az, cmd_el, cmd_is_tx,
        input  tbl_x, tbl_y, tbl_cal,
        input  pc_busy, pc_valid, pc_idx,
        output cmd_ready, tbl_addr,
        output pc_start, pc_is_tx, pc_x, pc_y, pc_az, pc_el,
        output wr_en, wr_addr, wr_data,
        output busy, done, err_timeout
    );

    modport slave (
        output cmd_valid, cmd_az, cmd_el, cmd_is_tx,
        output tbl_x, tbl_y, tbl_cal,
        output pc_busy, pc_valid, pc_idx,
        input  cmd_ready, tbl_addr,
        input  pc_start, pc_is_tx, pc_x, pc_y, pc_az, pc_el,
        input  wr_en, wr_addr, wr_data,
        input  busy, done, err_timeout
    );
endinterface

// File: rtl/beam_phase_seq.sv
// Element-sweep sequencer: per beam command, walks every array element through
// table fetch, one phase calculation, calibration trim and a phase register write.
module beam_phase_seq #(
    parameter int unsigned N_ELEM  = 64,
    parameter int unsigned EAW     = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    beam_phase_seq_if.master bus
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam int unsigned DW = 16;
    localparam int unsigned PW = 6;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WRITE, S_DONE
    } state_t;

    state_t         state, state_d;
    logic           accept_c, start_c, timeout_c, advance_c;
    logic           ready_q, tx_q, err_q;
    logic [DW-1:0]  az_q, el_q, x_q, y_q;
    logic [PW-1:0]  cal_q, res_q;
    logic [EAW-1:0] elem;
    logic [CW-1:0]  cnt;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Next-state and single-cycle control strobes.
    always_comb begin
        state_d   = state;
        accept_c  = 1'b0;
        start_c   = 1'b0;
        timeout_c = 1'b0;
        advance_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.cmd_valid && ready_q) begin
                    accept_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: state_d = S_ISSUE;
            S_ISSUE: begin
                if (!bus.pc_busy && !rst) begin
                    start_c = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.pc_valid) begin
                    state_d = S_WRITE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    timeout_c = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_WRITE: begin
                if (elem == EAW'(N_ELEM - 1)) begin
                    state_d = S_DONE;
                end else begin
                    advance_c = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sweep operands, element walk, timeout counter and trimmed result.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
            tx_q    <= 1'b0;
            err_q   <= 1'b0;
            az_q    <= '0;
            el_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cal_q   <= '0;
            res_q   <= '0;
            elem    <= '0;
            cnt     <= '0;
        end else begin
            ready_q <= (state_d == S_IDLE);
            if (accept_c) begin
                az_q  <= bus.cmd_az;
                el_q  <= bus.cmd_el;
                tx_q  <= bus.cmd_is_tx;
                elem  <= '0;
                err_q <= 1'b0;
            end
            if (start_c) begin
                x_q   <= bus.tbl_x;
                y_q   <= bus.tbl_y;
                cal_q <= bus.tbl_cal;
                cnt   <= '0;
            end
            if (state == S_WAIT) begin
                if (bus.pc_valid) res_q <= bus.pc_idx + cal_q;
                else              cnt   <= cnt + CW'(1);
            end
            if (timeout_c) err_q <= 1'b1;
            if (advance_c) elem  <= elem + EAW'(1);
        end
    end

    // Operands pass straight from the table while issuing, then hold for the calculation.
    assign bus.cmd_ready   = ready_q;
    assign bus.tbl_addr    = elem;
    assign bus.pc_start    = start_c;
    assign bus.pc_is_tx    = tx_q;
    assign bus.pc_az       = az_q;
    assign bus.pc_el       = el_q;
    assign bus.pc_x        = (state == S_ISSUE) ? bus.tbl_x : x_q;
    assign bus.pc_y        = (state == S_ISSUE) ? bus.tbl_y : y_q;
    assign bus.wr_en       = (state == S_WRITE);
    assign bus.wr_addr     = elem;
    assign bus.wr_data     = res_q;
    assign bus.busy        = (state != S_IDLE);
    assign bus.done        = (state == S_DONE);
    assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_beam_phase_seq.sv
// Directed bench for beam_phase_seq: element ROM and latency-10 calculator models,
// event logs stamped by cycle, one task per scenario.
`timescale 1ns/1ps
module tb_beam_phase_seq;
    localparam int unsigned N_ELEM  = 4;
    localparam int unsigned EAW     = 8;
    localparam int unsigned TIMEOUT = 64;
    localparam int          LAT     = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    beam_phase_seq_if #(.EAW(EAW)) bus ();

    beam_phase_seq #(.N_ELEM(N_ELEM), .EAW(EAW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    int cyc = 0, acc_cyc = 0, acc_n = 0, wr_n = 0, st_n = 0, done_n = 0, done_cyc = 0;
    int due = 0, viol = 0;
    logic pending = 1'b0;
    logic [7:0] cur = 8'd0;
    logic hang = 1'b0, spur = 1'b0;

    logic [7:0]  wr_addr_log [32];
    logic [5:0]  wr_data_log [32];
    int          wr_cyc_log  [32];
    int          st_cyc_log  [32];
    logic [15:0] st_x_log [32], st_y_log [32], st_az_log [32], st_el_log [32];
    logic        st_tx_log [32];

    logic [15:0] rom_x [4], rom_y [4];
    logic [5:0]  rom_cal [4], res_tab [4];

    // Element table: registered read, data one cycle after the address.
    always @(posedge clk) begin
        bus.tbl_x   <= rom_x[bus.tbl_addr[1:0]];
        bus.tbl_y   <= rom_y[bus.tbl_addr[1:0]];
        bus.tbl_cal <= rom_cal[bus.tbl_addr[1:0]];
    end

    // Calculator model answers LAT cycles after the start pulse; element id rides in pc_x[7:0].
    assign bus.pc_valid = (pending && (cyc == due)) || spur;
    assign bus.pc_idx   = res_tab[cur[1:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pending && (cyc == due)) pending <= 1'b0;
        if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) begin
            acc_cyc <= cyc;
            acc_n   <= acc_n + 1;
        end
        if (bus.pc_start === 1'b1) begin
            due     <= cyc + LAT;
            pending <= !hang;
            cur     <= bus.pc_x[7:0];
            if (bus.pc_busy === 1'b1) viol <= viol + 1;
            if (st_n < 32) begin
                st_cyc_log[st_n] <= cyc;
                st_x_log[st_n]   <= bus.pc_x;
                st_y_log[st_n]   <= bus.pc_y;
                st_az_log[st_n]  <= bus.pc_az;
                st_el_log[st_n]  <= bus.pc_el;
                st_tx_log[st_n]  <= bus.pc_is_tx;
            end
            st_n <= st_n + 1;
        end
        if (bus.wr_en === 1'b1) begin
            if (wr_n < 32) begin
                wr_addr_log[wr_n] <= bus.wr_addr;
                wr_data_log[wr_n] <= bus.wr_data;
                wr_cyc_log[wr_n]  <= cyc;
            end
            wr_n <= wr_n + 1;
        end
        if (bus.done === 1'b1) begin
            done_cyc <= cyc;
            done_n   <= done_n + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [15:0] az, input logic [15:0] el, input logic tx, input logic hold);
        int n;
        n = 0;
        bus.cmd_az    = az;
        bus.cmd_el    = el;
        bus.cmd_is_tx = tx;
        bus.cmd_valid = 1'b1;
        while (bus.cmd_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready, n);
        end
        tick();
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int n;
        n = 0;
        while (done_n == base && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (done_n == base) begin
            errors++;
            $display("FAIL done_wait: no done pulse within %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", bus.cmd_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        checks++; if ({bus.done, bus.wr_en, bus.pc_start, bus.err_timeout} !== 4'b0000) begin
            errors++; $display("FAIL rst_strobes: done/wr_en/pc_start/err=%b want 0000",
                               {bus.done, bus.wr_en, bus.pc_start, bus.err_timeout});
        end
        checks++; if (bus.tbl_addr !== 8'd0 || bus.wr_addr !== 8'd0 || bus.wr_data !== 6'd0) begin
            errors++; $display("FAIL rst_addr: tbl_addr=%0d wr_addr=%0d wr_data=%0d want 0", bus.tbl_addr, bus.wr_addr, bus.wr_data);
        end
        checks++; if (bus.pc_x !== 16'd0 || bus.pc_az !== 16'd0) begin
            errors++; $display("FAIL rst_operands: pc_x=%h pc_az=%h want 0", bus.pc_x, bus.pc_az);
        end
        rst = 1'b0;
        tick();
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", bus.cmd_ready); end
    endtask

    task automatic test_sweep();
        int wb, db, sb;
        logic [5:0] exp_d [4];
        exp_d = '{6'd5, 6'd17, 6'd42, 6'd63};
        res_tab = '{6'd5, 6'd17, 6'd42, 6'd63};
        rom_cal = '{6'd0, 6'd0, 6'd0, 6'd0};
        wb = wr_n; db = done_n; sb = st_n;
        send_cmd(16'h2D80, 16'h0A40, 1'b1, 1'b0);
        wait_done(db);
        checks++; if (wr_n - wb != 4) begin errors++; $display("FAIL sweep_count: writes=%0d want 4", wr_n - wb); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_addr_log[wb+i] !== 8'(i) || wr_data_log[wb+i] !== exp_d[i] || wr_cyc_log[wb+i] - acc_cyc != 13 + 13*i) begin
                errors++;
                $display("FAIL sweep_write%0d: addr=%0d data=%0d at +%0d want addr=%0d data=%0d at +%0d",
                         i, wr_addr_log[wb+i], wr_data_log[wb+i], wr_cyc_log[wb+i] - acc_cyc, i, exp_d[i], 13 + 13*i);
            end
        end
        checks++; if (st_cyc_log[sb] - acc_cyc != 2) begin errors++; $display("FAIL sweep_start: pc_start at +%0d want +2", st_cyc_log[sb] - acc_cyc); end
        checks++; if (st_az_log[sb] !== 16'h2D80 || st_el_log[sb] !== 16'h0A40 || st_tx_log[sb] !== 1'b1) begin
            errors++; $display("FAIL sweep_operands: az=%h el=%h tx=%b want 2d80 0a40 1", st_az_log[sb], st_el_log[sb], st_tx_log[sb]);
        end
        checks++; if (done_cyc - acc_cyc != 53) begin errors++; $display("FAIL sweep_done: done at +%0d want +53", done_cyc - acc_cyc); end
        checks++; if (bus.cmd_ready !== 1'b1 || cyc - acc_cyc != 54) begin
            errors++; $display("FAIL sweep_ready: cmd_ready=%b at +%0d want 1 at +54", bus.cmd_ready, cyc - acc_cyc);
        end
        checks++; if (bus.err_timeout !== 1'b0) begin errors++; $display("FAIL sweep_err: got %b want 0", bus.err_timeout); end
    endtask

    task automatic test_trim();
        int wb, db;
        logic [5:0] exp_d [4];
        exp_d = '{6'd3, 6'd63, 6'd0, 6'd1};
        res_tab = '{6'd60, 6'd0, 6'd33, 6'd1};
        rom_cal = '{6'd7, 6'd63, 6'd31, 6'd0};
        wb = wr_n; db = done_n;
        send_cmd(16'h0100, 16'h0200, 1'b0, 1'b0);
        wait_done(db);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_data_log[wb+i] !== exp_d[i]) begin
                errors++; $display("FAIL trim%0d: wr_data=%0d want %0d", i, wr_data_log[wb+i], exp_d[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int wb, db, sb;
        rom_cal = '{6'd0, 6'd0, 6'd0, 6'd0};
        hang = 1'b1;
        wb = wr_n; db = done_n; sb = st_n;
        send_cmd(16'h0300, 16'h0400, 1'b1, 1'b0);
        wait_done(db);
        checks++; if (wr_n != wb) begin errors++; $display("FAIL to_nowrite: writes=%0d want 0", wr_n - wb); end
        checks++; if (st_n - sb != 1) begin errors++; $display("FAIL to_starts: starts=%0d want 1", st_n - sb); end
        checks++; if (done_cyc - acc_cyc != 67) begin errors++; $display("FAIL to_done: done at +%0d want +67", done_cyc - acc_cyc); end
        tick();
        tick();
        checks++; if (bus.err_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: err_timeout=%b want 1", bus.err_timeout); end
        hang = 1'b0;
        db = done_n;
        send_cmd(16'h0500, 16'h0600, 1'b0, 1'b0);
        checks++; if (bus.err_timeout !== 1'b0) begin errors++; $display("FAIL to_clear: err_timeout=%b want 0", bus.err_timeout); end
        wait_done(db);
    endtask

    task automatic test_stall();
        int wb, db, sb;
        wb = wr_n; db = done_n; sb = st_n;
        send_cmd(16'h1111, 16'h2222, 1'b0, 1'b0);
        bus.pc_busy = 1'b1;
        repeat (6) tick();
        bus.pc_busy = 1'b0;
        wait_done(db);
        checks++; if (st_cyc_log[sb] - acc_cyc != 7) begin errors++; $display("FAIL stall_start: pc_start at +%0d want +7", st_cyc_log[sb] - acc_cyc); end
        checks++; if (st_x_log[sb] !== 16'h1200 || st_y_log[sb] !== 16'h3400) begin
            errors++; $display("FAIL stall_operands: pc_x=%h pc_y=%h want 1200 3400", st_x_log[sb], st_y_log[sb]);
        end
        checks++; if (st_x_log[sb+1] !== 16'h1201 || st_y_log[sb+1] !== 16'h3401) begin
            errors++; $display("FAIL stall_operands1: pc_x=%h pc_y=%h want 1201 3401", st_x_log[sb+1], st_y_log[sb+1]);
        end
        checks++; if (st_az_log[sb] !== 16'h1111 || st_el_log[sb] !== 16'h2222) begin
            errors++; $display("FAIL stall_beam: az=%h el=%h want 1111 2222", st_az_log[sb], st_el_log[sb]);
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL start_while_busy: count=%0d want 0", viol); end
        checks++; if (done_cyc - acc_cyc != 58) begin errors++; $display("FAIL stall_done: done at +%0d want +58", done_cyc - acc_cyc); end
        checks++; if (wr_n - wb != 4) begin errors++; $display("FAIL stall_count: writes=%0d want 4", wr_n - wb); end
    endtask

    task automatic test_back_to_back();
        int wb, db, ab, a0;
        res_tab = '{6'd9, 6'd10, 6'd11, 6'd12};
        wb = wr_n; db = done_n; ab = acc_n;
        send_cmd(16'h0700, 16'h0800, 1'b1, 1'b1);
        a0 = acc_cyc;
        spur = 1'b1;
        tick();
        spur = 1'b0;
        wait_done(db);
        checks++; if (acc_n - ab != 1) begin errors++; $display("FAIL b2b_hold: accepts=%0d before done+1 want 1", acc_n - ab); end
        checks++; if (wr_n - wb != 4 || wr_cyc_log[wb] - a0 != 13) begin
            errors++; $display("FAIL b2b_spurious: writes=%0d first at +%0d want 4 at +13", wr_n - wb, wr_cyc_log[wb] - a0);
        end
        tick();
        checks++; if (acc_n - ab != 2 || acc_cyc - a0 != 54) begin
            errors++; $display("FAIL b2b_second: accepts=%0d second at +%0d want 2 at +54", acc_n - ab, acc_cyc - a0);
        end
        bus.cmd_valid = 1'b0;
        wait_done(db + 1);
        checks++; if (wr_n - wb != 8 || wr_data_log[wb+7] !== 6'd12) begin
            errors++; $display("FAIL b2b_total: writes=%0d last=%0d want 8 and 12", wr_n - wb, wr_data_log[wb+7]);
        end
    endtask

    task automatic test_reset_mid();
        int wb, db, a0;
        res_tab = '{6'd21, 6'd22, 6'd23, 6'd24};
        wb = wr_n; db = done_n;
        send_cmd(16'h0900, 16'h0A00, 1'b1, 1'b0);
        a0 = acc_cyc;
        while (cyc < a0 + 30) tick();
        rst = 1'b1;
        tick();
        checks++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            errors++; $display("FAIL mid_rst_state: busy=%b cmd_ready=%b want 0 0", bus.busy, bus.cmd_ready);
        end
        checks++; if ({bus.wr_en, bus.pc_start, bus.done} !== 3'b000 || bus.tbl_addr !== 8'd0 || bus.pc_az !== 16'd0) begin
            errors++; $display("FAIL mid_rst_outputs: wr_en/pc_start/done=%b tbl_addr=%0d pc_az=%h want 000 0 0",
                               {bus.wr_en, bus.pc_start, bus.done}, bus.tbl_addr, bus.pc_az);
        end
        rst = 1'b0;
        repeat (12) tick();
        checks++; if (wr_n - wb != 2 || done_n != db) begin
            errors++; $display("FAIL mid_rst_quiet: writes=%0d dones=%0d want 2 0", wr_n - wb, done_n - db);
        end
        send_cmd(16'h0B00, 16'h0C00, 1'b0, 1'b0);
        wait_done(db);
        checks++; if (wr_n - wb != 6 || wr_addr_log[wb+2] !== 8'd0 || wr_data_log[wb+2] !== 6'd21) begin
            errors++; $display("FAIL mid_rst_restart: writes=%0d addr=%0d data=%0d want 6 0 21",
                               wr_n - wb, wr_addr_log[wb+2], wr_data_log[wb+2]);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_az    = 16'd0;
        bus.cmd_el    = 16'd0;
        bus.cmd_is_tx = 1'b0;
        bus.pc_busy   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rom_x[i]   = 16'(16'h1200 + i);
            rom_y[i]   = 16'(16'h3400 + i);
            rom_cal[i] = 6'd0;
            res_tab[i] = 6'd0;
        end
        test_reset();
        test_sweep();
        test_trim();
        test_timeout();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
